// File: rtl/rotator_pkg.sv
// Shared encodings for the parameterised bit rotator: operation modes,
// direction constants and the controller state type.
package rotator_pkg;

  typedef enum logic [1:0] {
    MODE_ROT     = 2'b00,
    MODE_LSH     = 2'b01,
    MODE_ASH     = 2'b10,
    MODE_ROT_ALT = 2'b11
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Shift modes saturate their step count at WIDTH; rotates wrap modulo WIDTH.
  function automatic logic is_shift(mode_e m);
    return (m == MODE_LSH) || (m == MODE_ASH);
  endfunction

endpackage

// File: rtl/rot_step.sv
// One-position move of a WIDTH-bit word: rotate, logical shift or
// arithmetic shift, left or right. Purely combinational.
module rot_step
  import rotator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  mode_e            mode_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] data_o
);

  logic fill_lsb;
  logic fill_msb;

  // Pick the bit entering the vacated end, then assemble the moved word.
  always_comb begin
    fill_lsb = 1'b0;
    fill_msb = 1'b0;
    unique case (mode_i)
      MODE_ROT, MODE_ROT_ALT: begin
        fill_lsb = data_i[WIDTH-1];
        fill_msb = data_i[0];
      end
      MODE_LSH: begin
        fill_lsb = 1'b0;
        fill_msb = 1'b0;
      end
      MODE_ASH: begin
        // Left arithmetic shift is the same as a logical left shift.
        fill_lsb = 1'b0;
        fill_msb = data_i[WIDTH-1];
      end
      default: begin
        fill_lsb = 1'b0;
        fill_msb = 1'b0;
      end
    endcase

    if (dir_i == DIR_LEFT) begin
      data_o = {data_i[WIDTH-2:0], fill_lsb};
    end else begin
      data_o = {fill_msb, data_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/param_bit_rotator.sv
// Multi-cycle bit rotator/shifter: accepts an operand in IDLE, moves it one
// position per clock in RUN, then publishes the result with a one-cycle done.
module param_bit_rotator
  import rotator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    amount,
  input  logic             rotate_dir,
  input  logic [1:0]       mode,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] work_q;
  logic [AW-1:0]    cnt_q;
  logic [AW-1:0]    steps_d;
  logic             dir_q;
  mode_e            mode_q;
  mode_e            mode_in;
  logic [WIDTH-1:0] data_out_q;
  logic             done_q;
  logic [WIDTH-1:0] step_out;
  logic             accept;

  assign mode_in = mode_e'(mode);
  assign accept  = (state_q == ST_IDLE) && start;

  // Step count for the incoming request: shifts saturate at WIDTH, rotates wrap.
  always_comb begin
    steps_d = '0;
    if (is_shift(mode_in)) begin
      steps_d = (amount > WIDTH_A) ? WIDTH_A : amount;
    end else begin
      steps_d = amount % WIDTH_A;
    end
  end

  rot_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .data_i(work_q),
    .mode_i(mode_q),
    .dir_i (dir_q),
    .data_o(step_out)
  );

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE on start, leave RUN once the counter is spent.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    in_ready = (state_q == ST_IDLE);
    busy     = (state_q == ST_RUN);
  end

  // Working register, step counter, latched controls and the published result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q     <= '0;
      cnt_q      <= '0;
      dir_q      <= DIR_LEFT;
      mode_q     <= MODE_ROT;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        work_q <= data_in;
        cnt_q  <= steps_d;
        dir_q  <= rotate_dir;
        mode_q <= mode_in;
      end else if (state_q == ST_RUN) begin
        if (cnt_q != '0) begin
          work_q <= step_out;
          cnt_q  <= cnt_q - AW'(1);
        end else begin
          data_out_q <= work_q;
          done_q     <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_param_bit_rotator.sv
// Scoreboard bench for param_bit_rotator at WIDTH=8: expected results and
// latencies are queued on acceptance and checked when done pulses.
module tb_param_bit_rotator;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start;
  logic [W-1:0]  data_in;
  logic [AW-1:0] amount;
  logic          rotate_dir;
  logic [1:0]    mode;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic [W-1:0]  data_out;

  param_bit_rotator #(.WIDTH(W), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .amount    (amount),
    .rotate_dir(rotate_dir),
    .mode      (mode),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           last_done_cyc = -100;
  logic [W-1:0] prev_dout = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input int a,
                                               input logic dir, input logic [1:0] m);
    logic signed [W-1:0] sd;
    logic [W-1:0]        res;
    int                  r;
    sd = d;
    case (m)
      2'b01: begin
        if (a >= W) res = '0;
        else if (dir) res = d >> a;
        else res = d << a;
      end
      2'b10: begin
        if (!dir) begin
          if (a >= W) res = '0;
          else res = d << a;
        end else if (a >= W) begin
          res = {W{d[W-1]}};
        end else begin
          sd  = sd >>> a;
          res = sd;
        end
      end
      default: begin
        r = a % W;
        if (r == 0) res = d;
        else if (dir) res = (d >> r) | (d << (W - r));
        else res = (d << r) | (d >> (W - r));
      end
    endcase
    return res;
  endfunction

  function automatic int ref_lat(input int a, input logic [1:0] m);
    if (m == 2'b01 || m == 2'b10) return ((a > W) ? W : a) + 1;
    return (a % W) + 1;
  endfunction

  // Monitor: pop and compare on every done; data_out must otherwise hold.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (done) begin
        last_done_cyc = cyc;
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("data_out", data_out, e.data);
          chk("latency", cyc - e.acc, e.lat);
        end
      end else if (data_out !== prev_dout) begin
        chk("dout_hold", data_out, prev_dout);
      end
      prev_dout = data_out;
    end
  end

  // Hold start until the DUT is ready, then record the accepting edge.
  task automatic accept_op(input logic [W-1:0] exp_d, input int exp_l);
    exp_t e;
    int   i;
    i = 0;
    while (!in_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      start = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      e.data = exp_d;
      e.lat  = exp_l;
      e.acc  = cyc;
      sb.push_back(e);
      start = 1'b0;
    end
  endtask

  task automatic run_op(input logic [W-1:0] d, input int a, input logic dir,
                        input logic [1:0] m, input logic [W-1:0] exp_d, input int exp_l);
    @(negedge clk);
    data_in    = d;
    amount     = AW'(a);
    rotate_dir = dir;
    mode       = m;
    start      = 1'b1;
    accept_op(exp_d, exp_l);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] d;
    int           a;
    logic         dir;
    logic [1:0]   m;

    start = 1'b0; data_in = '0; amount = '0; rotate_dir = 1'b0; mode = 2'b00;
    #1 reset = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data_out", data_out, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Directed vectors with literal expectations.
    run_op(8'b10110011, 3, 1'b0, 2'b00, 8'b10011101, 4);
    run_op(8'b10110011, 2, 1'b1, 2'b10, 8'b11101100, 3);
    run_op(8'b10110011, 1, 1'b1, 2'b00, 8'b11011001, 2);
    run_op(8'b10110011, 8, 1'b0, 2'b00, 8'b10110011, 1);
    run_op(8'b10110011, 9, 1'b0, 2'b01, 8'b00000000, 9);
    run_op(8'b10000000, 12, 1'b1, 2'b10, 8'b11111111, 9);
    run_op(8'b10110011, 8, 1'b1, 2'b01, 8'b00000000, 9);
    run_op(8'b10110011, 11, 1'b1, 2'b11, 8'b01110110, 4);
    run_op(8'b01110011, 15, 1'b1, 2'b10, 8'b00000000, 9);
    wait_drain();

    // Randomised operations checked against the reference model.
    for (int k = 0; k < 40; k++) begin
      d   = W'($urandom);
      a   = $urandom_range(0, 15);
      dir = 1'($urandom_range(0, 1));
      m   = 2'($urandom_range(0, 3));
      run_op(d, a, dir, m, ref_result(d, a, dir, m), ref_lat(a, m));
    end
    wait_drain();

    // Start while busy is ignored; start held through done is accepted next edge.
    run_op(8'h5A, 5, 1'b0, 2'b00, 8'h4B, 6);
    @(negedge clk); @(negedge clk);
    data_in = 8'hFF; amount = AW'(1); rotate_dir = 1'b0; mode = 2'b01; start = 1'b1;
    chk("busy_during_run", busy, 1);
    chk("not_ready_in_run", in_ready, 0);
    accept_op(8'hFE, 2);
    chk("b2b_accept_cycle", cyc, last_done_cyc + 1);
    wait_drain();

    // Asynchronous reset in the middle of a 5-step operation.
    run_op(8'h3C, 5, 1'b0, 2'b00, 8'h87, 6);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    sb.delete();
    prev_dout = '0;
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    run_op(8'b10110011, 3, 1'b1, 2'b01, 8'b00010110, 4);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
